// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchroniser, ready handshake and stop-bit framing error
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          fall, tick;
  always_comb begin
    fall = rx_d & ~rx_s;
    tick = (state != IDLE) && (cnt == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_d, rx_s, rx_m} <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
      if (clr_rdy) rdy <= 1'b0;
      if (state != IDLE && !tick) cnt <= cnt - CW'(1);
      // completion set is last so it wins over clr_rdy in the same cycle
      case (state)
        IDLE: if (fall) begin
          state <= START;
          cnt <= HALF;
          rdy <= 1'b0;
        end
        START: if (tick) begin
          state <= rx_s ? IDLE : DATA;
          cnt <= FULL;
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          shreg <= {rx_s, shreg[7:1]};
          cnt <= FULL;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state <= STOP;
        end
        STOP: if (tick) begin
          rx_data <= shreg;
          frm_err <= ~rx_s;
          rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames driven from a bit-accurate serial model, checked against hand-computed bytes
module tb_uart_rx;
  localparam int B = 32;
  localparam int LAT = 3 + B / 2 + 9 * B;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err;
  int         cyc = 0, t0 = 0, t_rdy = 0, n_chk = 0, n_err = 0;
  logic       rdy_p = 1'b0;

  uart_rx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rdy && !rdy_p) t_rdy = cyc;
    rdy_p = rdy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    t0 = cyc;
    hold(1'b0, B);
    for (int i = 0; i < 8; i++) hold(d[i], B);
    hold(stop, B);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1 clr_rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdy", rdy, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frm_err, 0);
    hold(1'b1, 4);
    send(8'hA5, 1'b1);
    chk("lat", t_rdy - t0, LAT);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", frm_err, 0);
    send(8'h00, 1'b1);
    chk("b2b0_data", rx_data, 8'h00);
    chk("b2b0_rdy", rdy, 1);
    send(8'hFF, 1'b1);
    chk("b2b1_data", rx_data, 8'hFF);
    chk("b2b1_rdy", rdy, 1);
    pulse_clr();
    chk("clr_rdy", rdy, 0);
    hold(1'b0, 8);
    hold(1'b1, 2 * B);
    chk("glitch_rdy", rdy, 0);
    chk("glitch_data", rx_data, 8'hFF);
    send(8'h3C, 1'b1);
    chk("3c_data", rx_data, 8'h3C);
    send(8'h5A, 1'b0);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_ferr", frm_err, 1);
    chk("5a_rdy", rdy, 1);
    hold(1'b1, B);
    send(8'h81, 1'b1);
    chk("81_data", rx_data, 8'h81);
    chk("81_ferr", frm_err, 0);
    fork
      send(8'h66, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
      end
    join
    chk("clr_vs_set", rdy, 1);
    chk("66_data", rx_data, 8'h66);
    send(8'h00, 1'b0);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_ferr", frm_err, 1);
    pulse_clr();
    hold(1'b0, 12 * B);
    chk("brk_norestart", rdy, 0);
    hold(1'b1, B);
    fork
      send(8'hE7, 1'b1);
      begin
        repeat (5 * B + B / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_ferr", frm_err, 0);
        chk("mid_rst_rdy", rdy, 0);
      end
    join
    hold(1'b1, 12 * B);
    pulse_clr();
    send(8'hC3, 1'b1);
    chk("c3_data", rx_data, 8'hC3);
    chk("c3_ferr", frm_err, 0);
    chk("c3_rdy", rdy, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
